instr_mem_arbiter: RTL and testbench

Arbitration and sequencing controller for the 256×8 instruction memory. It shares the memory's single address/data port between two requesters:
- the processor fetch path, which performs reads at the PC;
- a program loader, which streams a byte block into memory at a chosen base address.

Loads have priority and stall fetching until the block is written. The block sits between the PC/decode logic, the external loader and the instruction memory.

---
 rtl/instr_mem_arbiter.sv | 107 ++++++++++
 tb/tb_instr_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_arbiter.sv
// Shares the single port of the instruction memory between the fetch path and a program loader.
// Loads take priority and hold the PC via stall until the whole block has been written.
module instr_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              stall,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_count,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_byte,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic              start_load;
  logic              last_byte;

  // A block longer than the memory would only overwrite itself, so cap it at one full pass.
  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] count);
    return (count > DEPTH) ? DEPTH : count;
  endfunction

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = fetch_addr;
    mem_wdata  = load_byte;
    start_load = 1'b0;
    last_byte  = 1'b0;
    case (state)
      IDLE: begin
        if (load_start && (load_count != '0)) begin
          start_load = 1'b1;
          state_next = LOAD;
        end else if (fetch_req) begin
          state_next = FETCH;
        end
      end
      FETCH: state_next = IDLE;
      LOAD: begin
        stall      = 1'b1;
        load_ready = 1'b1;
        mem_addr   = ptr;
        mem_we     = load_valid;
        if (load_valid && (remaining == ONE)) begin
          last_byte  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        stall      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      load_done   <= 1'b0;
      ptr         <= '0;
      remaining   <= '0;
    end else begin
      state       <= state_next;
      fetch_valid <= (state == FETCH);
      load_done   <= last_byte;
      if (state == FETCH) begin
        fetch_data <= mem_rdata;
      end
      // Pointer wraps naturally at the top of memory, so a block may straddle 0xFF/0x00.
      if (start_load) begin
        ptr       <= load_base;
        remaining <= clamp_count(load_count);
      end else if ((state == LOAD) && load_valid) begin
        ptr       <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Bench for instr_mem_arbiter: attached synchronous memory, transaction-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_instr_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       fetch_valid;
  logic [7:0] fetch_data;
  logic       stall;
  logic       load_start;
  logic [7:0] load_base;
  logic [8:0] load_count;
  logic       load_valid;
  logic [7:0] load_byte;
  logic       load_ready;
  logic       load_done;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  instr_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .stall(stall),
    .load_start(load_start), .load_base(load_base), .load_count(load_count),
    .load_valid(load_valid), .load_byte(load_byte),
    .load_ready(load_ready), .load_done(load_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Attached 256x8 memory with one-cycle synchronous read.
  logic [7:0] mem [256];
  logic       mem_init = 1'b0;
  int         wr_count = 0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 8'h10) ? 8'hA5 : 8'(i) ^ 8'h5A;
      mem_init <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
    mem_rdata <= mem[mem_addr];
  end

  // Reference model: what memory should hold, plus the outstanding fetch / load session.
  logic [7:0] ref_mem [256];
  logic       ref_init = 1'b0;
  logic       m_valid  = 1'b0;
  logic       e_fv;
  logic [7:0] e_fd;
  int         m_left;
  int         m_ptr;
  logic       m_done;
  logic       m_fetch;
  logic [7:0] m_faddr;
  always @(posedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] <= (i == 8'h10) ? 8'hA5 : 8'(i) ^ 8'h5A;
      ref_init <= 1'b1;
    end
    if (!reset) begin
      m_valid <= 1'b1;
      e_fv    <= 1'b0;
      e_fd    <= 8'h00;
      m_left  <= 0;
      m_ptr   <= 0;
      m_done  <= 1'b0;
      m_fetch <= 1'b0;
      m_faddr <= 8'h00;
    end else begin
      e_fv <= m_fetch;
      if (m_fetch) begin
        e_fd    <= ref_mem[m_faddr];
        m_fetch <= 1'b0;
      end else if (m_done) begin
        m_done <= 1'b0;
      end else if (m_left > 0) begin
        if (load_valid) begin
          ref_mem[m_ptr] <= load_byte;
          m_ptr          <= (m_ptr + 1) % 256;
          m_left         <= m_left - 1;
          if (m_left == 1) m_done <= 1'b1;
        end
      end else if (load_start && load_count != 0) begin
        m_left <= (load_count > 256) ? 256 : int'(load_count);
        m_ptr  <= int'(load_base);
      end else if (fetch_req) begin
        m_fetch <= 1'b1;
        m_faddr <= fetch_addr;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
        chk("fetch_data", 32'(fetch_data), 32'(e_fd));
        chk("stall", 32'(stall), 32'((m_left > 0) || m_done));
        chk("load_ready", 32'(load_ready), 32'(m_left > 0));
        chk("load_done", 32'(load_done), 32'(m_done));
        chk("mem_we", 32'(mem_we), 32'((m_left > 0) && load_valid));
        if (m_left > 0) begin
          chk("mem_addr_load", 32'(mem_addr), 32'(m_ptr));
          if (load_valid) chk("mem_wdata", 32'(mem_wdata), 32'(load_byte));
        end else if (!m_done && !m_fetch) begin
          chk("mem_addr_idle", 32'(mem_addr), 32'(fetch_addr));
        end
      end
    end
  endtask

  // Inputs change just after the falling edge, clear of both sampling points.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [7:0] addr, input logic [7:0] exp, input bit hold,
                          input string name);
    int n;
    fetch_req  = 1'b1;
    fetch_addr = addr;
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (fetch_valid) begin
        n = k;
        break;
      end
    end
    chk({name, "_latency"}, 32'(n), 32'd2);
    chk({name, "_data"}, 32'(fetch_data), 32'(exp));
    if (!hold) fetch_req = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] base, input logic [8:0] count, input int nbytes,
                          input int gap, input int abort_at, input logic [7:0] seed,
                          input string name);
    load_start = 1'b1;
    load_base  = base;
    load_count = count;
    step();
    load_start = 1'b0;
    chk({name, "_stall_on"}, 32'(stall), 32'd1);
    for (int i = 0; i < nbytes; i++) begin
      if (i == abort_at) begin
        load_valid = 1'b0;
        reset      = 1'b0;
        step();
        reset = 1'b1;
        chk({name, "_stall_after_reset"}, 32'(stall), 32'd0);
        step();
        chk({name, "_no_done_after_reset"}, 32'(load_done), 32'd0);
        return;
      end
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          load_valid = 1'b0;
          step();
        end
      end
      load_valid = 1'b1;
      load_byte  = seed + 8'(i * 17);
      step();
    end
    load_valid = 1'b0;
    chk({name, "_done"}, 32'(load_done), 32'd1);
    step();
    chk({name, "_done_pulse"}, 32'(load_done), 32'd0);
  endtask

  initial begin
    int lat;
    int wr_before;
    reset      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 8'h00;
    load_start = 1'b0;
    load_base  = 8'h00;
    load_count = 9'd0;
    load_valid = 1'b0;
    load_byte  = 8'h00;
    fork
      compare_loop();
    join_none
    repeat (3) step();
    chk("reset_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("reset_fetch_data", 32'(fetch_data), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_load_done", 32'(load_done), 32'd0);
    reset = 1'b1;
    step();

    do_fetch(8'h10, 8'hA5, 1'b0, "fetch_10");
    step();

    do_fetch(8'h00, 8'h5A, 1'b1, "b2b_0");
    do_fetch(8'h01, 8'h5B, 1'b1, "b2b_1");
    do_fetch(8'h02, 8'h58, 1'b0, "b2b_2");
    step();

    run_load(8'hFE, 9'd4, 4, 0, -1, 8'h11, "wrap_load");
    chk("wrap_mem_FE", 32'(mem[8'hFE]), 32'h11);
    chk("wrap_mem_FF", 32'(mem[8'hFF]), 32'h22);
    chk("wrap_mem_00", 32'(mem[8'h00]), 32'h33);
    chk("wrap_mem_01", 32'(mem[8'h01]), 32'h44);
    do_fetch(8'h00, 8'h33, 1'b0, "fetch_after_load");
    step();

    // Load and fetch requested together: the load wins, the fetch follows DONE.
    fetch_req  = 1'b1;
    fetch_addr = 8'h05;
    load_start = 1'b1;
    load_base  = 8'h05;
    load_count = 9'd1;
    load_valid = 1'b1;
    load_byte  = 8'h7E;
    step();
    load_start = 1'b0;
    chk("tie_stall", 32'(stall), 32'd1);
    step();
    load_valid = 1'b0;
    chk("tie_load_done", 32'(load_done), 32'd1);
    chk("tie_no_fetch_yet", 32'(fetch_valid), 32'd0);
    lat = 0;
    for (int k = 3; k <= 12; k++) begin
      step();
      if (fetch_valid) begin
        lat = k;
        break;
      end
    end
    chk("tie_fetch_latency", 32'(lat), 32'd5);
    chk("tie_fetch_data", 32'(fetch_data), 32'h7E);
    fetch_req = 1'b0;
    step();

    run_load(8'h40, 9'd3, 3, 2, 2, 8'hC1, "abort_load");
    chk("abort_mem_40", 32'(mem[8'h40]), 32'hC1);
    chk("abort_mem_41", 32'(mem[8'h41]), 32'hD2);
    chk("abort_mem_42", 32'(mem[8'h42]), 32'h18);
    step();

    load_start = 1'b1;
    load_base  = 8'h80;
    load_count = 9'd0;
    step();
    load_start = 1'b0;
    chk("zero_count_stall", 32'(stall), 32'd0);
    chk("zero_count_done", 32'(load_done), 32'd0);
    step();
    chk("zero_count_done_later", 32'(load_done), 32'd0);

    wr_before = wr_count;
    run_load(8'h80, 9'd300, 256, 0, -1, 8'h00, "clamp_load");
    step();
    chk("clamp_write_count", 32'(wr_count - wr_before), 32'd256);
    do_fetch(8'h7F, 8'hEF, 1'b0, "fetch_clamp_last");
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
